// File: rtl/conv_pe_sequencer.sv
// Convolution PE sequencer: drives per-pixel PE reset/finish strobes for one layer
// pass and packs completed OFM words into the next-stage BRAM via a 4-beat writeback.
module conv_pe_sequencer #(
    parameter int NUM_PIXELS       = 3136,
    parameter int CYCLES_PER_PIXEL = 36,
    parameter int ARM_CYCLES       = 3,
    parameter int NUM_PE           = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [NUM_PE-1:0] valid,
    output logic              cal_start,
    output logic [NUM_PE-1:0] PE_reset,
    output logic [NUM_PE-1:0] PE_finish,
    output logic              wr_en_next,
    output logic [31:0]       addr_ram_next_wr,
    output logic [1:0]        control_mux,
    output logic              busy,
    output logic              done,
    output logic              overrun
);

    localparam int PW   = $clog2(NUM_PIXELS + 1);
    localparam int CMAX = (ARM_CYCLES > CYCLES_PER_PIXEL) ? ARM_CYCLES : CYCLES_PER_PIXEL;
    localparam int CW   = $clog2(CMAX + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARM,
        S_PRST,
        S_ACC,
        S_FIN,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t        state;
    state_t        next_state;
    logic [CW-1:0] phase_cnt;
    logic [PW-1:0] pix_cnt;
    logic [PW:0]   pix_cnt_inc;
    logic          wb_trig;
    logic          wb_last;
    logic          wb_start;

    assign pix_cnt_inc = {1'b0, pix_cnt} + (PW + 1)'(1);
    assign wb_trig     = &valid;
    assign wb_last     = wr_en_next && (control_mux == 2'd3);
    assign wb_start    = wb_trig && (!wr_en_next || wb_last);

    always_comb begin
        next_state = state;
        case (state)
            S_IDLE:  if (start) next_state = S_ARM;
            S_ARM:   if (phase_cnt == CW'(ARM_CYCLES - 1)) next_state = S_PRST;
            S_PRST:  next_state = S_ACC;
            S_ACC:   if (phase_cnt == CW'(CYCLES_PER_PIXEL - 3)) next_state = S_FIN;
            S_FIN:   next_state = (pix_cnt_inc < (PW + 1)'(NUM_PIXELS)) ? S_PRST : S_DRAIN;
            S_DRAIN: if (!wr_en_next && !wb_trig) next_state = S_DONE;
            S_DONE:  next_state = S_IDLE;
            default: next_state = S_IDLE;
        endcase
    end

    // Outputs are decoded from next_state so they line up with the state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            phase_cnt <= '0;
            pix_cnt   <= '0;
            cal_start <= 1'b0;
            PE_reset  <= '0;
            PE_finish <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= next_state;
            phase_cnt <= (next_state != state) ? '0 : phase_cnt + CW'(1);
            if (next_state == S_IDLE)
                pix_cnt <= '0;
            else if (state == S_FIN)
                pix_cnt <= pix_cnt + PW'(1);
            cal_start <= (next_state == S_ARM) || (next_state == S_PRST) || (next_state == S_ACC)
                         || (next_state == S_FIN) || (next_state == S_DRAIN);
            PE_reset  <= {NUM_PE{next_state == S_PRST}};
            PE_finish <= {NUM_PE{next_state == S_FIN}};
            busy      <= (next_state != S_IDLE);
            done      <= (next_state == S_DONE);
        end
    end

    // A trigger on the final beat chains a new burst; earlier in a burst it is dropped.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_en_next       <= 1'b0;
            control_mux      <= 2'd0;
            addr_ram_next_wr <= '0;
            overrun          <= 1'b0;
        end else begin
            if (wb_start) begin
                wr_en_next  <= 1'b1;
                control_mux <= 2'd0;
            end else if (wb_last) begin
                wr_en_next  <= 1'b0;
                control_mux <= 2'd0;
            end else if (wr_en_next) begin
                control_mux <= control_mux + 2'd1;
            end
            if (wb_trig && wr_en_next && !wb_last)
                overrun <= 1'b1;
            if (wr_en_next)
                addr_ram_next_wr <= addr_ram_next_wr + 32'd1;
        end
    end

endmodule

// File: tb/tb_conv_pe_sequencer.sv
// Directed self-checking bench for conv_pe_sequencer with a two-pixel layer pass.
module tb_conv_pe_sequencer;

    localparam int NPE = 16;

    logic           clk = 1'b0;
    logic           reset;
    logic           start;
    logic [NPE-1:0] valid;
    logic           cal_start;
    logic [NPE-1:0] PE_reset;
    logic [NPE-1:0] PE_finish;
    logic           wr_en_next;
    logic [31:0]    addr_ram_next_wr;
    logic [1:0]     control_mux;
    logic           busy;
    logic           done;
    logic           overrun;

    int checks   = 0;
    int failures = 0;

    conv_pe_sequencer #(
        .NUM_PIXELS      (2),
        .CYCLES_PER_PIXEL(36),
        .ARM_CYCLES      (3),
        .NUM_PE          (NPE)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .start           (start),
        .valid           (valid),
        .cal_start       (cal_start),
        .PE_reset        (PE_reset),
        .PE_finish       (PE_finish),
        .wr_en_next      (wr_en_next),
        .addr_ram_next_wr(addr_ram_next_wr),
        .control_mux     (control_mux),
        .busy            (busy),
        .done            (done),
        .overrun         (overrun)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        start = 1'b0;
        valid = '0;
        apply_reset();
        checks++; if (cal_start !== 1'b0) begin failures++; $display("FAIL reset_cal_start got=%b exp=0", cal_start); end
        checks++; if (PE_reset !== '0) begin failures++; $display("FAIL reset_pe_reset got=%h exp=0", PE_reset); end
        checks++; if (PE_finish !== '0) begin failures++; $display("FAIL reset_pe_finish got=%h exp=0", PE_finish); end
        checks++; if (wr_en_next !== 1'b0) begin failures++; $display("FAIL reset_wr_en got=%b exp=0", wr_en_next); end
        checks++; if (control_mux !== 2'd0) begin failures++; $display("FAIL reset_mux got=%0d exp=0", control_mux); end
        checks++; if (addr_ram_next_wr !== 32'd0) begin failures++; $display("FAIL reset_addr got=%0d exp=0", addr_ram_next_wr); end
        checks++; if ({busy, done, overrun} !== 3'b000) begin failures++; $display("FAIL reset_flags got=%b exp=000", {busy, done, overrun}); end
    endtask

    // One two-pixel pass, checked cycle by cycle. Cycle k=1 is the cycle after start is sampled.
    // inject_start: extra start pulses while busy. return_valid: full valid at each FIN cycle.
    task automatic run_pass(input string tag, input bit inject_start, input bit return_valid);
        int done_cnt = 0;
        int wr_cnt   = 0;
        int last_cal = return_valid ? 80 : 76;
        int base     = int'(addr_ram_next_wr);
        logic           exp_cal, exp_busy, exp_done, exp_wr;
        logic [NPE-1:0] exp_prst, exp_pfin;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 1; k <= 90; k++) begin
            exp_cal  = (k <= last_cal);
            exp_busy = (k <= last_cal + 1);
            exp_done = (k == last_cal + 1);
            exp_prst = (k == 4 || k == 40) ? '1 : '0;
            exp_pfin = (k == 39 || k == 75) ? '1 : '0;
            exp_wr   = return_valid && ((k >= 40 && k <= 43) || (k >= 76 && k <= 79));
            checks++; if (cal_start !== exp_cal) begin failures++; $display("FAIL %s cal_start k=%0d got=%b exp=%b", tag, k, cal_start, exp_cal); end
            checks++; if (busy !== exp_busy) begin failures++; $display("FAIL %s busy k=%0d got=%b exp=%b", tag, k, busy, exp_busy); end
            checks++; if (done !== exp_done) begin failures++; $display("FAIL %s done k=%0d got=%b exp=%b", tag, k, done, exp_done); end
            checks++; if (PE_reset !== exp_prst) begin failures++; $display("FAIL %s pe_reset k=%0d got=%h exp=%h", tag, k, PE_reset, exp_prst); end
            checks++; if (PE_finish !== exp_pfin) begin failures++; $display("FAIL %s pe_finish k=%0d got=%h exp=%h", tag, k, PE_finish, exp_pfin); end
            checks++; if (wr_en_next !== exp_wr) begin failures++; $display("FAIL %s wr_en k=%0d got=%b exp=%b", tag, k, wr_en_next, exp_wr); end
            if (exp_wr) begin
                checks++; if (addr_ram_next_wr !== 32'(base + wr_cnt)) begin failures++; $display("FAIL %s addr k=%0d got=%0d exp=%0d", tag, k, addr_ram_next_wr, base + wr_cnt); end
                checks++; if (control_mux !== 2'(wr_cnt % 4)) begin failures++; $display("FAIL %s mux k=%0d got=%0d exp=%0d", tag, k, control_mux, wr_cnt % 4); end
                wr_cnt++;
            end
            if (done) done_cnt++;
            start = inject_start && (k == 10 || k == 39 || k == 50 || k == 76);
            valid = (return_valid && (k == 39 || k == 75)) ? '1 : '0;
            tick();
        end
        start = 1'b0;
        valid = '0;
        checks++; if (done_cnt !== 1) begin failures++; $display("FAIL %s done_count got=%0d exp=1", tag, done_cnt); end
        checks++; if (overrun !== 1'b0) begin failures++; $display("FAIL %s overrun got=%b exp=0", tag, overrun); end
        if (return_valid) begin
            checks++; if (addr_ram_next_wr !== 32'(base + 8)) begin failures++; $display("FAIL %s final_addr got=%0d exp=%0d", tag, addr_ram_next_wr, base + 8); end
        end
    endtask

    task automatic test_pass();
        run_pass("pass", 1'b0, 1'b0);
    endtask

    task automatic test_start_ignored();
        run_pass("start_ignored", 1'b1, 1'b0);
    endtask

    task automatic test_partial_valid();
        valid = 16'h7FFF;
        for (int k = 0; k < 6; k++) begin
            tick();
            checks++; if (wr_en_next !== 1'b0) begin failures++; $display("FAIL partial_valid wr_en k=%0d got=%b exp=0", k, wr_en_next); end
        end
        valid = '0;
        checks++; if (addr_ram_next_wr !== 32'd0) begin failures++; $display("FAIL partial_valid addr got=%0d exp=0", addr_ram_next_wr); end
    endtask

    task automatic test_writeback();
        apply_reset();
        for (int b = 0; b < 2; b++) begin
            valid = '1;
            tick();
            valid = '0;
            for (int i = 0; i < 4; i++) begin
                checks++; if (wr_en_next !== 1'b1) begin failures++; $display("FAIL wb wr_en b=%0d i=%0d got=%b exp=1", b, i, wr_en_next); end
                checks++; if (control_mux !== 2'(i)) begin failures++; $display("FAIL wb mux b=%0d i=%0d got=%0d exp=%0d", b, i, control_mux, i); end
                checks++; if (addr_ram_next_wr !== 32'(4 * b + i)) begin failures++; $display("FAIL wb addr b=%0d i=%0d got=%0d exp=%0d", b, i, addr_ram_next_wr, 4 * b + i); end
                tick();
            end
            checks++; if ({wr_en_next, control_mux} !== 3'b000) begin failures++; $display("FAIL wb idle b=%0d got=%b exp=000", b, {wr_en_next, control_mux}); end
            checks++; if (addr_ram_next_wr !== 32'(4 * b + 4)) begin failures++; $display("FAIL wb idle_addr b=%0d got=%0d exp=%0d", b, addr_ram_next_wr, 4 * b + 4); end
            // Next trigger lands 36 cycles after this one.
            for (int w = 0; w < 31; w++) tick();
        end
    endtask

    task automatic test_back_to_back();
        apply_reset();
        valid = '1;
        tick();
        for (int c = 1; c <= 8; c++) begin
            checks++; if (wr_en_next !== 1'b1) begin failures++; $display("FAIL b2b wr_en c=%0d got=%b exp=1", c, wr_en_next); end
            checks++; if (control_mux !== 2'((c - 1) % 4)) begin failures++; $display("FAIL b2b mux c=%0d got=%0d exp=%0d", c, control_mux, (c - 1) % 4); end
            checks++; if (addr_ram_next_wr !== 32'(c - 1)) begin failures++; $display("FAIL b2b addr c=%0d got=%0d exp=%0d", c, addr_ram_next_wr, c - 1); end
            valid = (c == 4) ? '1 : '0;
            tick();
        end
        checks++; if (wr_en_next !== 1'b0) begin failures++; $display("FAIL b2b end wr_en got=%b exp=0", wr_en_next); end
        checks++; if (overrun !== 1'b0) begin failures++; $display("FAIL b2b overrun got=%b exp=0", overrun); end
    endtask

    task automatic test_overrun();
        apply_reset();
        valid = '1;
        tick();
        for (int c = 1; c <= 4; c++) begin
            checks++; if (control_mux !== 2'(c - 1) || wr_en_next !== 1'b1) begin failures++; $display("FAIL ovr burst c=%0d got=%b/%0d exp=1/%0d", c, wr_en_next, control_mux, c - 1); end
            valid = (c == 2) ? '1 : '0;
            tick();
        end
        for (int c = 5; c <= 8; c++) begin
            checks++; if (wr_en_next !== 1'b0) begin failures++; $display("FAIL ovr dropped c=%0d got=%b exp=0", c, wr_en_next); end
            checks++; if (overrun !== 1'b1) begin failures++; $display("FAIL ovr sticky c=%0d got=%b exp=1", c, overrun); end
            tick();
        end
        checks++; if (addr_ram_next_wr !== 32'd4) begin failures++; $display("FAIL ovr addr got=%0d exp=4", addr_ram_next_wr); end
    endtask

    task automatic test_reset_mid();
        apply_reset();
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 1; k < 20; k++) begin
            valid = (k == 17) ? '1 : '0;
            tick();
        end
        valid = '0;
        checks++; if (control_mux !== 2'd2 || busy !== 1'b1) begin failures++; $display("FAIL rst_mid precond mux/busy got=%0d/%b exp=2/1", control_mux, busy); end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++; if ({cal_start, busy, done, overrun} !== 4'b0000) begin failures++; $display("FAIL rst_mid flags got=%b exp=0000", {cal_start, busy, done, overrun}); end
        checks++; if ({PE_reset, PE_finish} !== '0) begin failures++; $display("FAIL rst_mid pe got=%h exp=0", {PE_reset, PE_finish}); end
        checks++; if ({wr_en_next, control_mux} !== 3'b000) begin failures++; $display("FAIL rst_mid wb got=%b exp=000", {wr_en_next, control_mux}); end
        checks++; if (addr_ram_next_wr !== 32'd0) begin failures++; $display("FAIL rst_mid addr got=%0d exp=0", addr_ram_next_wr); end
        for (int k = 0; k < 4; k++) begin
            tick();
            checks++; if (wr_en_next !== 1'b0 || cal_start !== 1'b0) begin failures++; $display("FAIL rst_mid quiet k=%0d got=%b%b exp=00", k, wr_en_next, cal_start); end
        end
    endtask

    task automatic test_full_pass();
        run_pass("full_pass", 1'b0, 1'b1);
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        valid = '0;
        test_reset();
        test_pass();
        test_start_ignored();
        test_partial_valid();
        test_writeback();
        test_back_to_back();
        test_overrun();
        test_reset_mid();
        test_full_pass();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/conv_pe_sequencer.md
CONV_PE_SEQUENCER -- requirements
Module: conv_pe_sequencer

Interface
REQ-001 Parameter NUM_PIXELS, 3136, number of OFM pixels per layer pass (56x56).
REQ-002 Parameter CYCLES_PER_PIXEL, 36, clock cycles per OFM pixel (tiles x kernel_W); legal range 6..255.
REQ-003 Parameter ARM_CYCLES, 3, cycles between cal_start rising and the first PE_reset.
REQ-004 Parameter NUM_PE, 16, PE lanes driven in lock-step.
REQ-005 clk  in  1  single clock; all logic on the rising edge.
REQ-006 reset  in  1  synchronous, active-high reset.
REQ-007 start  in  1  one-cycle request to run one layer pass; sampled only in IDLE.
REQ-008 valid  in  NUM_PE  per-PE OFM-valid from the CONV datapath.
REQ-009 cal_start  out  1  datapath calculation enable.
REQ-010 PE_reset  out  NUM_PE  accumulator clear, all lanes equal.
REQ-011 PE_finish  out  NUM_PE  accumulate-end strobe, all lanes equal.
REQ-012 wr_en_next  out  1  write enable of the next-stage BRAM.
REQ-013 addr_ram_next_wr  out  32  next-stage BRAM write address.
REQ-014 control_mux  out  2  byte-lane select of the OFM packer.
REQ-015 busy  out  1  high in every state except IDLE.
REQ-016 done  out  1  one-cycle pulse at the end of a pass.
REQ-017 overrun  out  1  sticky error flag: valid arrived while writeback was active.

Function
REQ-018 All outputs shall be registered.
REQ-019 Pixel FSM states: IDLE, ARM, PRST, ACC, FIN, DRAIN, DONE.
REQ-020 IDLE -> ARM on start=1; the cycle after start is sampled, cal_start=1 and busy=1.
REQ-021 ARM shall last exactly ARM_CYCLES cycles, then go to PRST.
REQ-022 PRST shall last 1 cycle, with PE_reset all ones; PE_reset shall be zero in every other state.
REQ-023 ACC shall last CYCLES_PER_PIXEL-2 cycles, with PE_reset and PE_finish zero.
REQ-024 FIN shall last 1 cycle, with PE_finish all ones; it increments a pixel counter (width clog2(NUM_PIXELS+1)).
REQ-025 From FIN: if pixel count < NUM_PIXELS, go to PRST; otherwise go to DRAIN. PE_reset-to-PE_reset period shall be exactly CYCLES_PER_PIXEL.
REQ-026 cal_start shall be 1 in ARM, PRST, ACC, FIN and DRAIN, and 0 in IDLE and DONE.
REQ-027 DRAIN shall wait until the writeback engine is idle and valid has not all bits set, then go to DONE.
REQ-028 DONE shall last 1 cycle with done=1, then go to IDLE; the pixel counter clears on entering IDLE.
REQ-029 start asserted outside IDLE shall be ignored.
REQ-030 Writeback engine runs independently of the pixel FSM; its trigger is valid == all ones (partial valid is ignored).
REQ-031 On a trigger with the engine idle: for the next 4 cycles, wr_en_next=1 and control_mux=0,1,2,3 in order.
REQ-032 addr_ram_next_wr shall be presented with each write and increment by 1 after each write.
REQ-033 The first write after reset uses address 0; the address wraps 0xFFFFFFFF -> 0 and persists across passes until reset.
REQ-034 wr_en_next=0 and control_mux=0 when the engine is idle.
REQ-035 A trigger in the last write cycle (control_mux=3) shall start a new burst back-to-back in the next cycle.
REQ-036 A trigger in any earlier burst cycle shall be dropped and set overrun=1, held until reset.

Reset
REQ-037 reset=1 at any clock edge shall force IDLE and zero the pixel counter and write address.
REQ-038 Reset outputs: cal_start 0, PE_reset 0, PE_finish 0, wr_en_next 0, control_mux 0, addr_ram_next_wr 0, busy 0, done 0, overrun 0.
REQ-039 Reset mid-pass or mid-burst shall abort immediately with no further writes.

Verification
REQ-040 NUM_PIXELS=2, CYCLES_PER_PIXEL=36, start pulse -> cal_start high 1 cycle later; PE_reset at +4 and +40; PE_finish at +39 and +75; done after drain; busy low after done.
REQ-041 valid=16'hFFFF for 1 cycle -> 4 cycles of wr_en_next with control_mux 0,1,2,3 and addresses 0,1,2,3; second trigger 36 cycles later -> addresses 4..7.
REQ-042 Second trigger exactly 4 cycles after the first -> contiguous 8-cycle burst at addresses 0..7, overrun=0; trigger 2 cycles after the first -> dropped, overrun=1.
REQ-043 valid=16'h7FFF -> no write; start pulses during busy -> pass timing unchanged, single done.
REQ-044 reset asserted in ACC of pixel 1 and during control_mux=2 -> next cycle all outputs at reset values; new start produces a full pass beginning at address 0.
REQ-045 Full default pass (3136 pixels, valid returned per pixel) -> exactly 12544 writes, final address 12543, done once, overrun=0.
